// File: rtl/ddfs_sweep_ctrl.sv
// ddfs_sweep_ctrl: stepped FTW sweep sequencer (IDLE/ARMED/RUN). Optional triangular loop via DDFS_SWEEP_PINGPONG_EN.
module ddfs_sweep_ctrl #(
    parameter int FTW_W   = 24,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [FTW_W-1:0]   cfg_start,
    input  logic [FTW_W-1:0]   cfg_stop,
    input  logic [FTW_W-1:0]   cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               cfg_loop,
    input  logic               go,
    input  logic               abort,
    output logic [FTW_W-1:0]   ftw,
    output logic               ftw_upd,
    output logic               phase_clr,
    output logic               busy,
    output logic               done
);
    typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;
    state_t state, state_nx;
    logic [FTW_W-1:0]   r_start, r_stop, r_step, ftw_nx, tgt;
    logic [DWELL_W-1:0] r_dwell, dcnt, dcnt_nx;
    logic               r_loop, up, up_nx, to_stop, to_stop_nx;
    logic               upd_nx, clr_nx, done_nx, cfg_take, expired, at_tgt;

    // one step from val toward tgt, computed one bit wider so overshoot or wrap clamps to tgt
    function automatic logic [FTW_W-1:0] step_to(input logic [FTW_W-1:0] val, input logic [FTW_W-1:0] stp,
                                                 input logic [FTW_W-1:0] t, input logic inc);
        logic [FTW_W:0] s;
        s = inc ? {1'b0, val} + {1'b0, stp} : {1'b0, val} - {1'b0, stp};
        return (inc ? s > {1'b0, t} : (s[FTW_W] || s[FTW_W-1:0] < t)) ? t : s[FTW_W-1:0];
    endfunction

    assign cfg_ready = state != RUN;
    assign busy      = state == RUN;
    assign tgt       = to_stop ? r_stop : r_start;
    assign expired   = dcnt == r_dwell - DWELL_W'(1);
    assign at_tgt    = ftw == tgt;

    // next-state and strobe generation; abort overrides everything
    always_comb begin
        state_nx   = state;
        ftw_nx     = ftw;
        dcnt_nx    = dcnt;
        up_nx      = up;
        to_stop_nx = to_stop;
        upd_nx     = 1'b0;
        clr_nx     = 1'b0;
        done_nx    = 1'b0;
        cfg_take   = 1'b0;
        if (abort) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    cfg_take = cfg_valid;
                    state_nx = cfg_valid ? ARMED : IDLE;
                end
                ARMED: begin
                    cfg_take = cfg_valid;
                    if (!cfg_valid && go) begin
                        state_nx   = RUN;
                        ftw_nx     = r_start;
                        dcnt_nx    = '0;
                        up_nx      = r_stop >= r_start;
                        to_stop_nx = 1'b1;
                        upd_nx     = 1'b1;
                        clr_nx     = 1'b1;
                    end
                end
                RUN: begin
                    dcnt_nx = expired ? '0 : dcnt + DWELL_W'(1);
                    if (expired && !at_tgt) begin
                        ftw_nx = step_to(ftw, r_step, tgt, up);
                        upd_nx = 1'b1;
                    end else if (expired && !r_loop) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end else if (expired) begin
`ifdef DDFS_SWEEP_PINGPONG_EN
                        up_nx      = ~up;
                        to_stop_nx = ~to_stop;
                        ftw_nx     = step_to(ftw, r_step, to_stop ? r_start : r_stop, ~up);
`else
                        ftw_nx     = r_start;
`endif
                        upd_nx = 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // state, tuning word, dwell counter and registered strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ftw       <= '0;
            dcnt      <= '0;
            up        <= 1'b1;
            to_stop   <= 1'b1;
            ftw_upd   <= 1'b0;
            phase_clr <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            ftw       <= ftw_nx;
            dcnt      <= dcnt_nx;
            up        <= up_nx;
            to_stop   <= to_stop_nx;
            ftw_upd   <= upd_nx;
            phase_clr <= clr_nx;
            done      <= done_nx;
        end
    end

    // latched sweep configuration with zero step/dwell promoted to one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_start <= '0;
            r_stop  <= '0;
            r_step  <= '0;
            r_dwell <= '0;
            r_loop  <= 1'b0;
        end else if (cfg_take) begin
            r_start <= cfg_start;
            r_stop  <= cfg_stop;
            r_step  <= cfg_step == '0 ? FTW_W'(1) : cfg_step;
            r_dwell <= cfg_dwell == '0 ? DWELL_W'(1) : cfg_dwell;
            r_loop  <= cfg_loop;
        end
    end
endmodule

// File: tb/tb_ddfs_sweep_ctrl.sv
// tb_ddfs_sweep_ctrl: directed and randomized sweeps checked against a list-based sweep model.
module tb_ddfs_sweep_ctrl;
    logic        clk = 1'b0, reset = 1'b1;
    logic        cfg_valid = 1'b0, cfg_ready, cfg_loop = 1'b0, go = 1'b0, abort = 1'b0;
    logic [23:0] cfg_start = '0, cfg_stop = '0, cfg_step = '0, ftw;
    logic [15:0] cfg_dwell = '0;
    logic        ftw_upd, phase_clr, busy, done;
    int          n_cmp = 0, n_bad = 0;
    logic [23:0] exp_q[$];

    ddfs_sweep_ctrl dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_step(cfg_step), .cfg_dwell(cfg_dwell),
        .cfg_loop(cfg_loop), .go(go), .abort(abort), .ftw(ftw), .ftw_upd(ftw_upd),
        .phase_clr(phase_clr), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // FTW values visited walking from a to b with clamping at b
    function automatic void append_seq(input logic [23:0] a, input logic [23:0] b, input logic [23:0] st, input bit skip_first);
        longint v = a, s = (st == 0) ? 1 : st, e = b;
        if (!skip_first) exp_q.push_back(a);
        while (v != e) begin
            if (e >= longint'(a)) v = (v + s > e) ? e : v + s;
            else v = (v - s < e) ? e : v - s;
            exp_q.push_back(24'(v));
        end
    endfunction

    task automatic send_cfg(input logic [23:0] a, input logic [23:0] b, input logic [23:0] st, input logic [15:0] dw, input bit lp);
        cfg_start = a; cfg_stop = b; cfg_step = st; cfg_dwell = dw; cfg_loop = lp; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("armed_ready", 32'(cfg_ready), 1);
        chk("armed_busy", 32'(busy), 0);
    endtask

    // configure, go, follow the sweep cycle by cycle; end by done, abort, or reset
    task automatic sweep(input logic [23:0] a, input logic [23:0] b, input logic [23:0] st, input logic [15:0] dw,
                         input bit lp, input int max_t, input int abort_t, input int cfg_t, input bit rst_end);
        int d = (dw == 0) ? 1 : int'(dw);
        int len, lim, k;
        exp_q.delete();
        append_seq(a, b, st, 0);
`ifdef DDFS_SWEEP_PINGPONG_EN
        if (lp && exp_q.size() > 1) begin
            append_seq(b, a, st, 1);
            void'(exp_q.pop_back());
        end
`endif
        len = exp_q.size();
        lim = lp ? max_t : len * d + 1;
        send_cfg(a, b, st, dw, lp);
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int t = 0; t < lim; t++) begin
            k = t / d;
            if (!lp && k >= len) begin
                chk("done_pulse", 32'(done), 1);
                chk("done_busy", 32'(busy), 0);
                chk("done_ftw", 32'(ftw), 32'(b));
                chk("done_upd", 32'(ftw_upd), 0);
                tick();
                chk("done_once", 32'(done), 0);
                chk("done_hold", 32'(ftw), 32'(b));
                return;
            end
            chk("ftw", 32'(ftw), 32'(exp_q[k % len]));
            chk("upd", 32'(ftw_upd), 32'(t % d == 0));
            chk("clr", 32'(phase_clr), 32'(t == 0));
            chk("busy", 32'(busy), 1);
            chk("nodone", 32'(done), 0);
            chk("run_ready", 32'(cfg_ready), 0);
            if (t == abort_t) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                chk("abort_busy", 32'(busy), 0);
                chk("abort_ftw", 32'(ftw), 32'(exp_q[k % len]));
                chk("abort_upd", 32'(ftw_upd), 0);
                chk("abort_done", 32'(done), 0);
                chk("abort_ready", 32'(cfg_ready), 1);
                go = 1'b1;
                tick();
                go = 1'b0;
                tick();
                chk("idle_go_busy", 32'(busy), 0);
                chk("idle_go_upd", 32'(ftw_upd), 0);
                chk("idle_go_done", 32'(done), 0);
                return;
            end
            if (t == cfg_t) begin
                cfg_valid = 1'b1; cfg_start = ~a; cfg_stop = ~b; cfg_step = 24'h5; go = 1'b1;
            end
            tick();
            cfg_valid = 1'b0; go = 1'b0;
        end
        if (rst_end) begin
            #2 reset = 1'b1;
            #1;
            chk("rst_ftw", 32'(ftw), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_ready", 32'(cfg_ready), 1);
            chk("rst_upd", 32'(ftw_upd), 0);
            tick();
            reset = 1'b0;
            tick();
            tick();
            chk("post_rst_upd", 32'(ftw_upd), 0);
            chk("post_rst_done", 32'(done), 0);
            chk("post_rst_ftw", 32'(ftw), 0);
        end else begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            chk("loop_abort_busy", 32'(busy), 0);
            chk("loop_abort_done", 32'(done), 0);
        end
    endtask

    initial begin
        logic [23:0] a, b, st, dl;
        logic [15:0] dw;
        bit          lp;
        int          ab, n;
        #3;
        chk("reset_ftw", 32'(ftw), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_upd", 32'(ftw_upd), 0);
        chk("reset_clr", 32'(phase_clr), 0);
        tick();
        reset = 1'b0;
        tick();
        chk("ready_after_reset", 32'(cfg_ready), 1);
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("idle_go_ignored", 32'(busy), 0);
        send_cfg(24'd900, 24'd1, 24'd7, 16'd9, 1'b1);
        sweep(24'd100, 24'd130, 24'd10, 16'd4, 1'b0, 0, -1, 2, 1'b0);
        sweep(24'd50, 24'd20, 24'd15, 16'd1, 1'b0, 0, -1, -1, 1'b0);
        sweep(24'd50, 24'd20, 24'd40, 16'd1, 1'b0, 0, -1, -1, 1'b0);
        sweep(24'd0, 24'd2, 24'd1, 16'd2, 1'b1, 20, -1, -1, 1'b0);
        sweep(24'd100, 24'd130, 24'd10, 16'd4, 1'b0, 0, 15, -1, 1'b0);
        sweep(24'd5, 24'd8, 24'd0, 16'd0, 1'b0, 0, -1, -1, 1'b0);
        sweep(24'hFFFFF0, 24'hFFFFFF, 24'h20, 16'd1, 1'b0, 0, -1, -1, 1'b0);
        sweep(24'h10, 24'h0, 24'h30, 16'd2, 1'b0, 0, -1, -1, 1'b0);
        sweep(24'd7, 24'd7, 24'd3, 16'd3, 1'b0, 0, -1, -1, 1'b0);
        sweep(24'd7, 24'd7, 24'd3, 16'd2, 1'b1, 8, -1, -1, 1'b0);
        sweep(24'd0, 24'd25, 24'd10, 16'd1, 1'b1, 16, -1, -1, 1'b0);
        sweep(24'd1000, 24'd5000, 24'd100, 16'd3, 1'b1, 10, -1, -1, 1'b1);
        for (int i = 0; i < 16; i++) begin
            a  = 24'($urandom_range(40000, 16700000));
            dl = 24'($urandom_range(1, 3000));
            b  = $urandom_range(0, 1) ? a + dl : a - dl;
            if ($urandom_range(0, 7) == 0) b = a;
            st = 24'($urandom_range(int'(dl) / 20 + 1, int'(dl) / 2 + 2));
            if ($urandom_range(0, 5) == 0) st = '0;
            if (st == 0) dl = 24'(0);
            if (st == 0) b = a + 24'($urandom_range(0, 6));
            dw = 16'($urandom_range(0, 4));
            lp = ($urandom_range(0, 3) == 0) && (a != b);
            n  = 40;
            ab = $urandom_range(0, 1) ? int'($urandom_range(0, 30)) : -1;
            sweep(a, b, st, dw, lp, n, ab, int'($urandom_range(0, 10)), 1'b0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ddfs_sweep_ctrl.md
Name: ddfs_sweep_ctrl

Overview:
Frequency-sweep sequencer for the ddfs phase-accumulator core. It accepts a sweep configuration (start/stop tuning word, step, dwell), and on a go command it issues a stepped series of frequency tuning words (FTW). Each FTW is held for a programmable number of clocks, with update and phase-clear strobes. It sits between the register/control interface and the ddfs tuning-word input, and is the only block that writes the ddfs FTW.

Parameters:
FTW_W  24  tuning-word / accumulator increment width
DWELL_W  16  dwell counter width (clocks per FTW)

Ports:
clk  in  1  system clock, all logic rising-edge
reset  in  1  asynchronous, active-high reset
cfg_valid  in  1  configuration offer
cfg_ready  out  1  config accepted when cfg_valid && cfg_ready
cfg_start  in  FTW_W  first FTW of sweep
cfg_stop  in  FTW_W  last FTW of sweep
cfg_step  in  FTW_W  FTW increment magnitude, unsigned
cfg_dwell  in  DWELL_W  clocks each FTW is held
cfg_loop  in  1  1 = repeat sweep until abort
go  in  1  start sweep (sampled only in ARMED)
abort  in  1  stop sweep immediately
ftw  out  FTW_W  registered tuning word to ddfs
ftw_upd  out  1  1-cycle pulse, ftw changed this cycle
phase_clr  out  1  1-cycle pulse, ddfs clears accumulator
busy  out  1  sweep in progress
done  out  1  1-cycle pulse, single sweep completed

Behaviour:
- Reset (async, active-high): state IDLE, ftw=0, ftw_upd=0, phase_clr=0, busy=0, done=0, config registers=0. cfg_ready=1 once out of reset.
- States: IDLE, ARMED, RUN.
- cfg_ready is 1 in IDLE and ARMED and 0 in RUN.
- Handshake: cfg_valid && cfg_ready latches all cfg_* fields and moves to ARMED. A reconfigure in ARMED overwrites the latched config. cfg_valid in RUN is ignored and not latched.
- Config normalisation at latch: step==0 is stored as 1; dwell==0 is stored as 1.
- Direction: up if stop >= start, else down. Fixed per config.
- go in ARMED at edge N:
  - At N+1: RUN, busy=1, ftw=start, ftw_upd=1, phase_clr=1.
  - go in IDLE or RUN has no effect.
- RUN:
  - Dwell counter counts D=dwell clocks per FTW.
  - On the D-th clock, if ftw != stop: ftw <= ftw +/- step, with ftw_upd=1 on the next cycle.
  - Overshoot rule: compute the next value in FTW_W+1 bits. If it passes stop (or wraps), clamp to stop. The final issued FTW is always exactly stop.
- Terminal, when ftw==stop and dwell has expired:
  - cfg_loop=0: next cycle done=1, busy=0, state IDLE, ftw holds stop.
  - cfg_loop=1: ftw <= start, ftw_upd=1, phase_clr=0, stay in RUN; done is not pulsed.
- start==stop: one FTW held for D clocks, then terminal as above.
- abort (any state, priority over go and cfg): next cycle IDLE, busy=0, ftw holds its current value, no done, no ftw_upd. The latched config is kept, but go requires a new config handshake (IDLE).
- Simultaneous terminal and abort: abort wins, no done.
- Reset mid-sweep forces all reset values immediately, asynchronously.
- ftw_upd and phase_clr never assert outside RUN entry/steps.

Optional Feature:
Macro DDFS_SWEEP_PINGPONG_EN.
- Defined: with cfg_loop=1, at the terminal point the direction reverses instead of reloading start (triangular sweep). The same step and clamp rule apply toward start. Endpoints are issued once per turn, never repeated back-to-back. Reversal at start likewise. phase_clr pulses only on go.
- Undefined: loop reloads start as described above (sawtooth).

Test Plan:
- Reset asserted mid-RUN -> same cycle ftw=0, busy=0, cfg_ready=1; no ftw_upd/done pulses after release.
- cfg start=100, stop=130, step=10, dwell=4, loop=0; go at N -> ftw 100@N+1, 110@N+5, 120@N+9, 130@N+13; ftw_upd at those cycles; phase_clr only at N+1; done=1 at N+17; busy low at N+17.
- Down sweep start=50, stop=20, step=15, dwell=1 -> ftw 50, 35, 20 on consecutive cycles, then done. Step=40 from 50 -> 50, then clamped 20, then done.
- Loop sweep start=0, stop=2, step=1, dwell=2, loop=1 -> 0, 1, 2, 0, 1, 2... each held 2 clocks, no done. With DDFS_SWEEP_PINGPONG_EN -> 0, 1, 2, 1, 0, 1, 2...
- abort asserted on the same cycle the terminal point is reached -> IDLE next cycle, done never pulses, ftw holds 130.
- cfg_valid during RUN -> cfg_ready=0, config unchanged; go during RUN ignored; step=0 and dwell=0 config behaves as step=1, dwell=1.
